// File: rtl/decode_stage.sv
// Decode stage: decodes one instruction word at a time and buffers the decoded
// results in a 2-entry FIFO between the fetch and execute handshakes.
module decode_stage #(
   parameter int MD_EN = 1,
   parameter int PC_W  = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   input  logic            flush,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [4:0]      out_id,
   output logic [4:0]      out_rs,
   output logic [4:0]      out_rt,
   output logic [4:0]      out_rd,
   output logic [15:0]     out_imm,
   output logic [PC_W-1:0] out_pc,
   output logic [4:0]      out_wa,
   output logic            out_rs_use,
   output logic            out_rt_use,
   output logic            out_ri,
   output logic            out_md
);

   localparam logic [4:0] ID_NOP = 5'd28;
   localparam logic [4:0] ID_RI  = 5'd31;

   typedef struct packed {
      logic [4:0]      id;
      logic [4:0]      rs;
      logic [4:0]      rt;
      logic [4:0]      rd;
      logic [4:0]      wa;
      logic [15:0]     imm;
      logic [PC_W-1:0] pc;
      logic            rsUse;
      logic            rtUse;
      logic            ri;
      logic            md;
   } entry_t;

   logic [4:0] w_rawId;
   logic [4:0] w_id;
   entry_t     w_dec;
   entry_t     w_empty;
   entry_t     w_head;
   logic       w_push;
   logic       w_pop;

   logic [1:0] r_count;
   logic       r_wrPtr;
   logic       r_rdPtr;
   entry_t     r_mem [2];

   // Opcode/funct lookup; R-type is selected by funct alone, the all-zero word is NOP.
   always_comb begin
      w_rawId = ID_RI;
      if (in_instr == 32'd0) begin
         w_rawId = ID_NOP;
      end else if (in_instr[31:26] == 6'b000000) begin
         case (in_instr[5:0])
            6'b100000: w_rawId = 5'd0;
            6'b100010: w_rawId = 5'd1;
            6'b100100: w_rawId = 5'd2;
            6'b100101: w_rawId = 5'd3;
            6'b101010: w_rawId = 5'd4;
            6'b101011: w_rawId = 5'd5;
            6'b001000: w_rawId = 5'd19;
            6'b011000: w_rawId = 5'd20;
            6'b011001: w_rawId = 5'd21;
            6'b011010: w_rawId = 5'd22;
            6'b011011: w_rawId = 5'd23;
            6'b010000: w_rawId = 5'd24;
            6'b010010: w_rawId = 5'd25;
            6'b010001: w_rawId = 5'd26;
            6'b010011: w_rawId = 5'd27;
            default:   w_rawId = ID_RI;
         endcase
      end else begin
         case (in_instr[31:26])
            6'b001111: w_rawId = 5'd6;
            6'b001000: w_rawId = 5'd7;
            6'b001100: w_rawId = 5'd8;
            6'b001101: w_rawId = 5'd9;
            6'b100011: w_rawId = 5'd10;
            6'b100001: w_rawId = 5'd11;
            6'b100000: w_rawId = 5'd12;
            6'b101011: w_rawId = 5'd13;
            6'b101001: w_rawId = 5'd14;
            6'b101000: w_rawId = 5'd15;
            6'b000100: w_rawId = 5'd16;
            6'b000101: w_rawId = 5'd17;
            6'b000011: w_rawId = 5'd18;
            default:   w_rawId = ID_RI;
         endcase
      end
   end

   // Without the mult/div unit the whole HI/LO group becomes reserved.
   always_comb begin
      w_id = w_rawId;
      if ((MD_EN == 0) && (w_rawId >= 5'd20) && (w_rawId <= 5'd27)) begin
         w_id = ID_RI;
      end
   end

   always_comb begin
      w_dec       = '0;
      w_dec.id    = w_id;
      w_dec.rs    = in_instr[25:21];
      w_dec.rt    = in_instr[20:16];
      w_dec.rd    = in_instr[15:11];
      w_dec.imm   = in_instr[15:0];
      w_dec.pc    = in_pc;
      w_dec.ri    = (w_id == ID_RI);
      w_dec.md    = (w_id >= 5'd20) && (w_id <= 5'd23);
      w_dec.rsUse = 1'b1;
      w_dec.rtUse = 1'b0;
      case (w_id)
         5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd24, 5'd25: w_dec.wa = in_instr[15:11];
         5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12:      w_dec.wa = in_instr[20:16];
         5'd18:                                            w_dec.wa = 5'd31;
         default:                                          w_dec.wa = 5'd0;
      endcase
      case (w_id)
         5'd6, 5'd18, 5'd24, 5'd25, ID_NOP, ID_RI: w_dec.rsUse = 1'b0;
         default:                                  w_dec.rsUse = 1'b1;
      endcase
      case (w_id)
         5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5,
         5'd13, 5'd14, 5'd15, 5'd16, 5'd17,
         5'd20, 5'd21, 5'd22, 5'd23:               w_dec.rtUse = 1'b1;
         default:                                  w_dec.rtUse = 1'b0;
      endcase
   end

   // Flush wins over any same-cycle handshake.
   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign w_push    = in_valid && in_ready && !flush;
   assign w_pop     = out_valid && out_ready && !flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= 2'd0;
         r_wrPtr <= 1'b0;
         r_rdPtr <= 1'b0;
      end else if (flush) begin
         r_count <= 2'd0;
         r_wrPtr <= 1'b0;
         r_rdPtr <= 1'b0;
      end else begin
         if (w_push) begin
            r_wrPtr <= ~r_wrPtr;
         end
         if (w_pop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   // Entry storage needs no reset: it is only visible while the count says it holds data.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= w_dec;
      end
   end

   always_comb begin
      w_empty    = '0;
      w_empty.id = ID_NOP;
      w_head     = out_valid ? r_mem[r_rdPtr] : w_empty;
   end

   assign out_id     = w_head.id;
   assign out_rs     = w_head.rs;
   assign out_rt     = w_head.rt;
   assign out_rd     = w_head.rd;
   assign out_imm    = w_head.imm;
   assign out_pc     = w_head.pc;
   assign out_wa     = w_head.wa;
   assign out_rs_use = w_head.rsUse;
   assign out_rt_use = w_head.rtUse;
   assign out_ri     = w_head.ri;
   assign out_md     = w_head.md;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised bench for decode_stage: two instances (with and without the
// mult/div group) share stimulus and are compared to a table-driven model.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        inValid;
   logic [31:0] inInstr;
   logic [31:0] inPc;
   logic        flush;
   logic        outReady;

   logic        readyA, validA, rsUseA, rtUseA, riA, mdA;
   logic [4:0]  idA, rsA, rtA, rdA, waA;
   logic [15:0] immA;
   logic [31:0] pcA;
   logic        readyB, validB, rsUseB, rtUseB, riB, mdB;
   logic [4:0]  idB, rsB, rtB, rdB, waB;
   logic [15:0] immB;
   logic [31:0] pcB;

   int checks = 0;
   int errors = 0;

   logic [31:0] qInstr[$];
   logic [31:0] qPc[$];

   typedef struct {
      int id;
      int wa;
      bit rsUse;
      bit rtUse;
      bit ri;
      bit md;
   } ref_t;

   decode_stage #(.MD_EN(1), .PC_W(32)) dutA (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(readyA),
      .in_instr(inInstr), .in_pc(inPc), .flush(flush), .out_ready(outReady),
      .out_valid(validA), .out_id(idA), .out_rs(rsA), .out_rt(rtA), .out_rd(rdA),
      .out_imm(immA), .out_pc(pcA), .out_wa(waA), .out_rs_use(rsUseA),
      .out_rt_use(rtUseA), .out_ri(riA), .out_md(mdA)
   );

   decode_stage #(.MD_EN(0), .PC_W(32)) dutB (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(readyB),
      .in_instr(inInstr), .in_pc(inPc), .flush(flush), .out_ready(outReady),
      .out_valid(validB), .out_id(idB), .out_rs(rsB), .out_rt(rtB), .out_rd(rdB),
      .out_imm(immB), .out_pc(pcB), .out_wa(waB), .out_rs_use(rsUseB),
      .out_rt_use(rtUseB), .out_ri(riB), .out_md(mdB)
   );

   always #5 clk = ~clk;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Instruction-set tables; the all-zero word doubles as the empty-FIFO output.
   function automatic ref_t decodeRef(input logic [31:0] w, input bit mdEn);
      int rFunct[15] = '{32, 34, 36, 37, 42, 43, 8, 24, 25, 26, 27, 16, 18, 17, 19};
      int rId[15]    = '{0, 1, 2, 3, 4, 5, 19, 20, 21, 22, 23, 24, 25, 26, 27};
      int iOp[13]    = '{15, 8, 12, 13, 35, 33, 32, 43, 41, 40, 4, 5, 3};
      ref_t r;
      int op;
      int funct;
      op = int'(w[31:26]);
      funct = int'(w[5:0]);
      r.id = 31;
      if (w == 32'd0) r.id = 28;
      else if (op == 0) begin
         for (int i = 0; i < 15; i++) if (rFunct[i] == funct) r.id = rId[i];
      end else begin
         for (int i = 0; i < 13; i++) if (iOp[i] == op) r.id = 6 + i;
      end
      if (!mdEn && r.id >= 20 && r.id <= 27) r.id = 31;
      r.ri = (r.id == 31);
      r.md = (r.id >= 20 && r.id <= 23);
      r.rsUse = !(r.id inside {6, 18, 24, 25, 28, 31});
      r.rtUse = (r.id inside {[0:5], [13:17], [20:23]});
      if (r.id inside {[0:5], 24, 25}) r.wa = int'(w[15:11]);
      else if (r.id inside {[6:12]}) r.wa = int'(w[20:16]);
      else if (r.id == 18) r.wa = 31;
      else r.wa = 0;
      return r;
   endfunction

   task automatic checkDut(input string n, input bit mdEn, input logic vld, input logic rdy,
                           input logic [4:0] id, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] wa, input logic [15:0] imm,
                           input logic [31:0] pc, input logic rsU, input logic rtU,
                           input logic ri, input logic md);
      logic [31:0] w;
      logic [31:0] p;
      ref_t r;
      w = 32'd0;
      p = 32'd0;
      if (qInstr.size() != 0) begin
         w = qInstr[0];
         p = qPc[0];
      end
      r = decodeRef(w, mdEn);
      checkOutput({n, "_valid"}, 64'(vld), 64'(qInstr.size() != 0));
      checkOutput({n, "_ready"}, 64'(rdy), 64'(qInstr.size() != 2));
      checkOutput({n, "_id"}, 64'(id), 64'(r.id));
      checkOutput({n, "_rs"}, 64'(rs), 64'(w[25:21]));
      checkOutput({n, "_rt"}, 64'(rt), 64'(w[20:16]));
      checkOutput({n, "_rd"}, 64'(rd), 64'(w[15:11]));
      checkOutput({n, "_imm"}, 64'(imm), 64'(w[15:0]));
      checkOutput({n, "_pc"}, 64'(pc), 64'(p));
      checkOutput({n, "_wa"}, 64'(wa), 64'(r.wa));
      checkOutput({n, "_rsUse"}, 64'(rsU), 64'(r.rsUse));
      checkOutput({n, "_rtUse"}, 64'(rtU), 64'(r.rtUse));
      checkOutput({n, "_ri"}, 64'(ri), 64'(r.ri));
      checkOutput({n, "_md"}, 64'(md), 64'(r.md));
   endtask

   task automatic checkAll();
      checkDut("A", 1'b1, validA, readyA, idA, rsA, rtA, rdA, waA, immA, pcA, rsUseA, rtUseA, riA, mdA);
      checkDut("B", 1'b0, validB, readyB, idB, rsB, rtB, rdB, waB, immB, pcB, rsUseB, rtUseB, riB, mdB);
   endtask

   // One clock of stimulus: drive at negedge, advance the model at the edge, check at the next negedge.
   task automatic applyStimulus(input bit v, input logic [31:0] instr, input bit oRdy, input bit fl);
      bit accept;
      bit pop;
      inValid  = v;
      inInstr  = instr;
      inPc     = $urandom;
      outReady = oRdy;
      flush    = fl;
      accept   = v && (qInstr.size() < 2);
      pop      = oRdy && (qInstr.size() > 0);
      @(posedge clk);
      if (fl) begin
         qInstr.delete();
         qPc.delete();
      end else begin
         if (pop) begin
            void'(qInstr.pop_front());
            void'(qPc.pop_front());
         end
         if (accept) begin
            qInstr.push_back(instr);
            qPc.push_back(inPc);
         end
      end
      @(negedge clk);
      checkAll();
   endtask

   function automatic logic [31:0] randInstr();
      int rFunct[15] = '{32, 34, 36, 37, 42, 43, 8, 24, 25, 26, 27, 16, 18, 17, 19};
      int iOp[13]    = '{15, 8, 12, 13, 35, 33, 32, 43, 41, 40, 4, 5, 3};
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 5))
         0: w = 32'd0;
         1, 2: begin
            w[31:26] = 6'd0;
            w[5:0] = 6'(rFunct[$urandom_range(0, 14)]);
         end
         3, 4: w[31:26] = 6'(iOp[$urandom_range(0, 12)]);
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      reset    = 1'b1;
      inValid  = 1'b0;
      inInstr  = 32'd0;
      inPc     = 32'd0;
      flush    = 1'b0;
      outReady = 1'b0;
      repeat (2) @(negedge clk);
      checkAll();
      reset = 1'b0;
      @(negedge clk);
      checkAll();

      $display("[TB] R-type ADD decode");
      applyStimulus(1'b1, 32'h02328020, 1'b1, 1'b0);
      checkOutput("addId", 64'(idA), 64'd0);
      checkOutput("addRs", 64'(rsA), 64'd17);
      checkOutput("addRt", 64'(rtA), 64'd18);
      checkOutput("addRd", 64'(rdA), 64'd16);
      checkOutput("addWa", 64'(waA), 64'd16);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);

      $display("[TB] fill to two entries and drain one");
      applyStimulus(1'b1, 32'h8FA80004, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0C000000, 1'b0, 1'b0);
      checkOutput("fullReady", 64'(readyA), 64'd0);
      checkOutput("lwId", 64'(idA), 64'd10);
      checkOutput("lwWa", 64'(waA), 64'd8);
      checkOutput("lwImm", 64'(immA), 64'h0004);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
      checkOutput("jalId", 64'(idA), 64'd18);
      checkOutput("jalWa", 64'(waA), 64'd31);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);

      $display("[TB] MULT with and without the mult/div group");
      applyStimulus(1'b1, 32'h00850018, 1'b0, 1'b0);
      checkOutput("multIdB", 64'(idB), 64'd31);
      checkOutput("multRiB", 64'(riB), 64'd1);
      checkOutput("multMdB", 64'(mdB), 64'd0);
      checkOutput("multIdA", 64'(idA), 64'd20);
      checkOutput("multMdA", 64'(mdA), 64'd1);
      checkOutput("multWaA", 64'(waA), 64'd0);

      $display("[TB] flush while full with a push");
      applyStimulus(1'b1, 32'h20010001, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h34020002, 1'b0, 1'b1);
      checkOutput("flushValid", 64'(validA), 64'd0);
      checkOutput("flushReady", 64'(readyA), 64'd1);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);

      $display("[TB] streaming at one entry");
      applyStimulus(1'b1, randInstr(), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, randInstr(), 1'b1, 1'b0);
         checkOutput("streamValid", 64'(validA), 64'd1);
         checkOutput("streamReady", 64'(readyA), 64'd1);
      end

      $display("[TB] asynchronous reset between edges");
      applyStimulus(1'b1, randInstr(), 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      qInstr.delete();
      qPc.delete();
      checkOutput("asyncValid", 64'(validA), 64'd0);
      checkOutput("asyncId", 64'(idA), 64'd28);
      checkOutput("asyncReady", 64'(readyA), 64'd1);
      inValid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      checkAll();
      applyStimulus(1'b1, 32'hFC00003F, 1'b0, 1'b0);
      checkOutput("rsvdId", 64'(idA), 64'd31);
      checkOutput("rsvdRi", 64'(riA), 64'd1);

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 3) != 0), randInstr(),
                       ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter MD_EN, default 1, meaning 1 decodes the mult/div/HI/LO group and 0 reports that group as reserved.
REQ-002 SHALL have parameter PC_W, default 32, meaning width of the carried PC tag.
REQ-003 SHALL have ports clk input 1 (system clock) and reset input 1 (reset); one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1, in_instr input 32 (instruction word), in_pc input PC_W (instruction address).
REQ-005 SHALL have ports flush input 1 (discard all buffered entries), out_ready input 1, out_valid output 1.
REQ-006 SHALL have ports out_id output 5, out_rs/out_rt/out_rd output 5 each, out_imm output 16, out_pc output PC_W.
REQ-007 SHALL have ports out_wa output 5 (destination register), out_rs_use output 1, out_rt_use output 1, out_ri output 1 (reserved instruction), out_md output 1 (mult/div start).

Function
REQ-008 SHALL decode R-type (op 000000) by funct: ADD 100000=0, SUB 100010=1, AND 100100=2, OR 100101=3, SLT 101010=4, SLTU 101011=5, JR 001000=19, MULT 011000=20, MULTU 011001=21, DIV 011010=22, DIVU 011011=23, MFHI 010000=24, MFLO 010010=25, MTHI 010001=26, MTLO 010011=27.
REQ-009 SHALL decode by op: LUI 001111=6, ADDI 001000=7, ANDI 001100=8, ORI 001101=9, LW 100011=10, LH 100001=11, LB 100000=12, SW 101011=13, SH 101001=14, SB 101000=15, BEQ 000100=16, BNE 000101=17, JAL 000011=18.
REQ-010 SHALL decode instr 0x00000000 as NOP id 28; any other encoding as id 31 with out_ri=1.
REQ-011 SHALL, when MD_EN=0, decode ids 20-27 as id 31 with out_ri=1.
REQ-012 SHALL set out_wa = rd for ids 0-5 and 24-25, rt for ids 6-12, 31 for id 18, and 0 otherwise.
REQ-013 SHALL set out_rs_use=1 for all ids except 6, 18, 24, 25, 28 and 31.
REQ-014 SHALL set out_rt_use=1 for ids 0-5, 13-17 and 20-23.
REQ-015 SHALL set out_md=1 for ids 20-23 only.
REQ-016 SHALL take out_rs, out_rt, out_rd and out_imm as raw fields [25:21], [20:16], [15:11], [15:0].
REQ-017 SHALL buffer decoded results in a 2-entry FIFO with count 0..2; in_ready = (count != 2), combinational from the registered count only.
REQ-018 SHALL accept when in_valid && in_ready and pop when out_valid && out_ready; simultaneous push and pop at count 1 keeps count at 1 and preserves order.
REQ-019 SHALL register decode at accept, so latency is 1 cycle: a word accepted at edge N is visible at the output after edge N when the FIFO was empty.
REQ-020 SHALL assert out_valid = (count != 0) and drive all out_* from the head entry; out_* SHALL hold stable while out_valid && !out_ready.
REQ-021 SHALL treat flush as synchronous and dominant: next count = 0, and a same-cycle push or pop has no effect.
REQ-022 SHALL drive out_* fields with zero, and out_id with 28, when count = 0.
REQ-023 SHALL implement the FIFO pointers as 1-bit wrap-around read and write indices.

Reset
REQ-024 SHALL, on reset assertion, immediately clear count and both pointers, with out_valid=0, out_id=28, and all other outputs 0; in_ready SHALL be 1.
REQ-025 SHALL discard in-flight entries when reset asserts mid-operation; the first accepted word after release is decoded normally.

Verification
REQ-026 Scenario: push 0x02328020 with out_ready=1 -> next cycle out_id=0, rs=17, rt=18, rd=16, wa=16, rs_use=1, rt_use=1.
REQ-027 Scenario: push 0x8FA80004 then 0x0C000000 with out_ready=0 -> in_ready=0 after 2 accepts; head id=10, wa=8, imm=0x0004; after 1 pop, id=18, wa=31.
REQ-028 Scenario: MD_EN=0, push 0x00850018 -> id=31, ri=1, md=0; MD_EN=1 -> id=20, md=1, wa=0.
REQ-029 Scenario: count=2, then flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the input word is lost.
REQ-030 Scenario: count=1 with in_valid=1 and out_ready=1 for 4 cycles -> count stays 1 and output ids follow input order exactly.
REQ-031 Scenario: reset pulse mid-stream between clock edges -> out_valid falls without waiting for an edge; 0xFC00003F yields id=31, ri=1.
